// File: rtl/mnist_nn_onchip_mem_arbiter_pkg.sv
// Shared types and default sizing for the on-chip memory arbiter slice.
package mnist_nn_mem_arb_pkg;

   localparam int ADDR_W_DEF = 2;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE
   } arb_state_e;

endpackage

// File: rtl/mnist_nn_onchip_mem_arbiter_if.sv
// Avalon-MM requester bus between one master and the arbiter's slave port.
interface mnist_nn_onchip_mem_arbiter_if
   import mnist_nn_mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [BE_W-1:0]   byteenable;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/mnist_nn_onchip_mem_arbiter_rr.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module mnist_nn_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   logic last_q, last_d;

   always_comb begin
      gnt_valid_o = |req_i;
      gnt_idx_o   = 1'b0;
      last_d      = last_q;
      if (req_i == 2'b10) begin
         gnt_idx_o = 1'b1;
      end else if (req_i == 2'b11) begin
         gnt_idx_o = ~last_q;
      end
      if (en_i && gnt_valid_o) begin
         last_d = gnt_idx_o;
      end
   end

   // Reset to 1 so requester 0 takes the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/mnist_nn_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between two Avalon-MM requesters.
module mnist_nn_onchip_mem_arbiter
   import mnist_nn_mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int BE_W  = DATA_W / 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   reset_req,
   mnist_nn_onchip_mem_arbiter_if.slave m0,
   mnist_nn_onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]      mem_address,
   output logic                   mem_chipselect,
   output logic                   mem_write,
   output logic [BE_W-1:0]        mem_byteenable,
   output logic [DATA_W-1:0]      mem_writedata,
   output logic                   mem_clken,
   input  logic [DATA_W-1:0]      mem_readdata
);

   arb_state_e        state_q, state_d;
   logic              gnt_q, gnt_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic              cmd_wr_q, cmd_wr_d;
   logic [BE_W-1:0]   cmd_be_q, cmd_be_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic              rdv0_q, rdv0_d, rdv1_q, rdv1_d;

   logic [1:0] req;
   logic       gnt_valid;
   logic       gnt_idx;

   assign req = {m1.read | m1.write, m0.read | m0.write};

   mnist_nn_rr_arbiter2 u_rr (
      .clk         (clk),
      .rst_n       (reset_n),
      .en_i        ((state_q == ST_IDLE) && !reset_req),
      .req_i       (req),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   // Every register defaults to hold, so reset_req freezes the block by
   // simply skipping all updates below.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wr_d    = cmd_wr_q;
      cmd_be_d    = cmd_be_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      rdv0_d      = rdv0_q;
      rdv1_d      = rdv1_q;
      if (!reset_req) begin
         rdv0_d = 1'b0;
         rdv1_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt_valid) begin
                  gnt_d   = gnt_idx;
                  state_d = ST_ISSUE;
                  if (gnt_idx) begin
                     cmd_addr_d  = m1.address;
                     cmd_wr_d    = m1.write;
                     cmd_be_d    = m1.byteenable;
                     cmd_wdata_d = m1.writedata;
                  end else begin
                     cmd_addr_d  = m0.address;
                     cmd_wr_d    = m0.write;
                     cmd_be_d    = m0.byteenable;
                     cmd_wdata_d = m0.writedata;
                  end
               end
            end
            ST_ISSUE: begin
               state_d = cmd_wr_q ? ST_IDLE : ST_CAPTURE;
            end
            ST_CAPTURE: begin
               state_d = ST_IDLE;
               if (gnt_q) begin
                  rdata1_d = mem_readdata;
                  rdv1_d   = 1'b1;
               end else begin
                  rdata0_d = mem_readdata;
                  rdv0_d   = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wr_q    <= 1'b0;
         cmd_be_q    <= '0;
         cmd_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         rdv0_q      <= 1'b0;
         rdv1_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wr_q    <= cmd_wr_d;
         cmd_be_q    <= cmd_be_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         rdv0_q      <= rdv0_d;
         rdv1_q      <= rdv1_d;
      end
   end

   assign m0.waitrequest   = !((state_q == ST_ISSUE) && !gnt_q);
   assign m1.waitrequest   = !((state_q == ST_ISSUE) && gnt_q);
   assign m0.readdata      = rdata0_q;
   assign m1.readdata      = rdata1_q;
   assign m0.readdatavalid = rdv0_q;
   assign m1.readdatavalid = rdv1_q;

   assign mem_address    = cmd_addr_q;
   assign mem_byteenable = cmd_be_q;
   assign mem_writedata  = cmd_wdata_q;
   assign mem_chipselect = (state_q == ST_ISSUE);
   assign mem_write      = (state_q == ST_ISSUE) && cmd_wr_q;
   assign mem_clken      = ~reset_req;

endmodule

// File: tb/tb_mnist_nn_onchip_mem_arbiter.sv
// Directed bench: two requesters driving the arbiter into a small RAM model.
module tb_mnist_nn_onchip_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        reset_req;
   logic [1:0]  mem_address;
   logic        mem_chipselect;
   logic        mem_write;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata = '0;

   logic [31:0] ram [4] = '{32'h0000_1000, 32'h0000_2001, 32'h0000_3002, 32'h0000_4003};

   int n_vec = 0;
   int n_err = 0;
   int grant_log [$];

   mnist_nn_onchip_mem_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m0_if ();
   mnist_nn_onchip_mem_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m1_if ();

   mnist_nn_onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .reset_req      (reset_req),
      .m0             (m0_if),
      .m1             (m1_if),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_byteenable (mem_byteenable),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data appears the cycle after the address is taken.
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
         end else begin
            mem_readdata <= ram[mem_address];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int n, input logic rd, input logic wr, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      if (n == 1) begin
         m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
         m1_if.writedata = d; m1_if.byteenable = be;
      end else begin
         m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
         m0_if.writedata = d; m0_if.byteenable = be;
      end
   endtask

   function automatic logic wreq(input int n);
      return (n == 1) ? m1_if.waitrequest : m0_if.waitrequest;
   endfunction

   function automatic logic rdv(input int n);
      return (n == 1) ? m1_if.readdatavalid : m0_if.readdatavalid;
   endfunction

   function automatic logic [31:0] rdat(input int n);
      return (n == 1) ? m1_if.readdata : m0_if.readdata;
   endfunction

   // Called at the negedge a command was driven; returns at the negedge after acceptance.
   task automatic wait_accept(input int n, inout int lat, output int acc_lat, output logic wr_seen);
      bit done = 0;
      wr_seen = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (!wreq(n)) begin
            done = 1;
            wr_seen = mem_write;
            grant_log.push_back(n);
         end
      end
      acc_lat = lat;
      if (!done) chk($sformatf("accept_tmo_m%0d", n), 32'd1, 32'd0);
      @(negedge clk);
      lat++;
      drive(n, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
   endtask

   task automatic wait_rdv(input int n, inout int lat, output logic [31:0] d);
      bit done = 0;
      d = '0;
      if (rdv(n)) done = 1;
      while (!done && lat < 60) begin
         @(negedge clk);
         lat++;
         if (rdv(n)) done = 1;
      end
      if (done) d = rdat(n);
      else chk($sformatf("rdv_tmo_m%0d", n), 32'd1, 32'd0);
   endtask

   task automatic do_write(input int n, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic rd_too,
                           output int acc_lat, output logic wr_seen);
      int lat = 0;
      drive(n, rd_too, 1'b1, a, d, be);
      wait_accept(n, lat, acc_lat, wr_seen);
   endtask

   task automatic do_read(input int n, input logic [1:0] a,
                          output int acc_lat, output int tot_lat, output logic [31:0] d);
      int  lat = 0;
      logic ws;
      drive(n, 1'b1, 1'b0, a, 32'd0, 4'hF);
      wait_accept(n, lat, acc_lat, ws);
      wait_rdv(n, lat, d);
      tot_lat = lat;
   endtask

   initial begin
      int          al, tl;
      logic        ws;
      logic [31:0] d;
      bit          seen;

      reset_n = 1'b0;
      reset_req = 1'b0;
      drive(0, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
      drive(1, 1'b0, 1'b0, 2'd0, 32'd0, 4'd0);
      repeat (3) @(negedge clk);
      chk("rst_wait0", {31'd0, m0_if.waitrequest}, 32'd1);
      chk("rst_wait1", {31'd0, m1_if.waitrequest}, 32'd1);
      chk("rst_rdv", {30'd0, m1_if.readdatavalid, m0_if.readdatavalid}, 32'd0);
      chk("rst_rdata0", m0_if.readdata, 32'd0);
      chk("rst_mem", {mem_address, mem_chipselect, mem_write, mem_byteenable}, 32'd0);
      chk("rst_clken", {31'd0, mem_clken}, 32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      // Simultaneous reads, each requester reissuing the instant its data returns.
      fork
         begin
            logic [31:0] x; int a1, t1;
            do_read(0, 2'd0, a1, t1, x); chk("rr_m0_a", x, 32'h0000_1000);
            do_read(0, 2'd0, a1, t1, x); chk("rr_m0_b", x, 32'h0000_1000);
         end
         begin
            logic [31:0] x; int a1, t1;
            do_read(1, 2'd1, a1, t1, x); chk("rr_m1_a", x, 32'h0000_2001);
            do_read(1, 2'd1, a1, t1, x); chk("rr_m1_b", x, 32'h0000_2001);
         end
      join
      chk("rr_count", grant_log.size(), 32'd4);
      if (grant_log.size() == 4) begin
         chk("rr_g0", grant_log[0], 32'd0);
         chk("rr_g1", grant_log[1], 32'd1);
         chk("rr_g2", grant_log[2], 32'd0);
         chk("rr_g3", grant_log[3], 32'd1);
      end
      @(negedge clk);

      do_write(0, 2'd2, 32'hDEAD_BEEF, 4'hF, 1'b0, al, ws);
      chk("wr_acc_lat", al, 32'd1);
      chk("wr_is_write", {31'd0, ws}, 32'd1);
      do_read(0, 2'd2, al, tl, d);
      chk("rd_acc_lat", al, 32'd1);
      chk("rd_rdv_lat", tl, 32'd3);
      chk("rd_data", d, 32'hDEAD_BEEF);

      do_write(1, 2'd3, 32'h1122_3344, 4'hF, 1'b0, al, ws);
      do_write(1, 2'd3, 32'h0000_AB00, 4'h2, 1'b0, al, ws);
      do_read(1, 2'd3, al, tl, d);
      chk("be_merge", d, 32'h1122_AB44);

      do_write(1, 2'd1, 32'h0000_0005, 4'hF, 1'b1, al, ws);
      chk("rdwr_is_write", {31'd0, ws}, 32'd1);
      seen = 0;
      repeat (3) begin @(negedge clk); if (m1_if.readdatavalid) seen = 1; end
      chk("rdwr_no_rdv", {31'd0, seen}, 32'd0);
      do_read(1, 2'd1, al, tl, d);
      chk("rdwr_readback", d, 32'h0000_0005);

      // Stall a read while it sits in CAPTURE.
      begin
         int lat = 0;
         drive(0, 1'b1, 1'b0, 2'd2, 32'd0, 4'hF);
         wait_accept(0, lat, al, ws);
         reset_req = 1'b1;
         repeat (5) begin
            #1;
            chk("stall_clken", {31'd0, mem_clken}, 32'd0);
            chk("stall_hold", {30'd0, m0_if.readdatavalid, mem_chipselect}, 32'd0);
            @(negedge clk);
         end
         reset_req = 1'b0;
         @(negedge clk);
         chk("stall_rdv", {31'd0, m0_if.readdatavalid}, 32'd1);
         chk("stall_data", m0_if.readdata, 32'hDEAD_BEEF);
      end

      // Hard reset while m1's read is being issued; m1 keeps requesting.
      begin
         int lat = 0;
         drive(1, 1'b1, 1'b0, 2'd1, 32'd0, 4'hF);
         @(negedge clk);
         chk("abort_in_issue", {31'd0, m1_if.waitrequest}, 32'd0);
         reset_n = 1'b0;
         #1;
         chk("abort_wait", {30'd0, m1_if.waitrequest, m0_if.waitrequest}, 32'd3);
         chk("abort_rdata0", m0_if.readdata, 32'd0);
         chk("abort_mem", {mem_address, mem_chipselect, mem_write, mem_byteenable}, 32'd0);
         seen = 0;
         repeat (2) begin @(negedge clk); if (m1_if.readdatavalid) seen = 1; end
         reset_n = 1'b1;
         @(negedge clk);
         if (m1_if.readdatavalid) seen = 1;
         chk("abort_no_rdv", {31'd0, seen}, 32'd0);
         wait_accept(1, lat, al, ws);
         wait_rdv(1, lat, d);
         chk("abort_retry_data", d, 32'h0000_0005);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
